// File: rtl/stepper_pkg.sv
// stepper_pkg: definitions shared between the stepper driver and the phase decoder.
//   STEP_PERIOD_W       width of step-period measurements (CLK100MHZ cycles)
//   STEP_PERIOD_FAST/SLOW  speed limits, expressed as step spacing in cycles
//   PH0..PH3            coil-phase codes {IN1, IN3} in forward order
//   dec_state_e         decoder FSM states
//   phase_next()        successor of a phase code in the forward direction
package stepper_pkg;

  localparam int          STEP_PERIOD_W    = 22;
  localparam int unsigned STEP_PERIOD_FAST = 550000;
  localparam int unsigned STEP_PERIOD_SLOW = 2000000;

  typedef logic [1:0] phase_t;

  // Gray-coded forward sequence: 00 -> 01 -> 11 -> 10 -> 00
  localparam phase_t PH0 = 2'b00;
  localparam phase_t PH1 = 2'b01;
  localparam phase_t PH2 = 2'b11;
  localparam phase_t PH3 = 2'b10;

  typedef enum logic [1:0] {
    DEC_PRIME = 2'd0,
    DEC_IDLE  = 2'd1,
    DEC_ARMED = 2'd2,
    DEC_TRACK = 2'd3
  } dec_state_e;

  function automatic phase_t phase_next(input phase_t p);
    case (p)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous level input.
//   clk_i   sampling clock
//   rst_ni  asynchronous active-low reset, clears both flops
//   d_i     asynchronous input level
//   q_o     synchronized level, two clk_i edges of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: decodes the two coil-phase levels of a stepper into a
// signed position, direction, per-step strobe and step-period measurement.
//   CLK100MHZ, CPU_RESETN   clock / async active-low reset
//   phase_a, phase_b        raw coil-phase levels (async)
//   clear                   synchronous position clear (wins over a step)
//   err_clr                 synchronous clear of the sticky illegal-transition flag
//   position, dir           step count and direction of the last legal step
//   step_pulse              one-cycle strobe per legal step
//   period, period_valid    cycles between the last two same-direction steps
//   stalled                 no legal step for STALL_LIMIT cycles
//   err                     sticky: both phases changed in one sample
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int          PERIOD_W    = STEP_PERIOD_W,
  parameter int          POS_W       = 32,
  parameter int unsigned STALL_LIMIT = 4000000
) (
  input  logic                       CLK100MHZ,
  input  logic                       CPU_RESETN,
  input  logic                       phase_a,
  input  logic                       phase_b,
  input  logic                       clear,
  input  logic                       err_clr,
  output logic signed [POS_W-1:0]    position,
  output logic                       dir,
  output logic                       step_pulse,
  output logic        [PERIOD_W-1:0] period,
  output logic                       period_valid,
  output logic                       stalled,
  output logic                       err
);

  // Counter is one bit wider than both the stall range and the period so
  // cnt+1 never overflows and the saturation compare is exact.
  localparam int LIM_W = $clog2(STALL_LIMIT);
  localparam int CNT_W = ((LIM_W > PERIOD_W) ? LIM_W : PERIOD_W) + 1;

  logic   a_sync, b_sync;
  phase_t s, chg;

  sync_2ff u_sync_a (.clk_i(CLK100MHZ), .rst_ni(CPU_RESETN), .d_i(phase_a), .q_o(a_sync));
  sync_2ff u_sync_b (.clk_i(CLK100MHZ), .rst_ni(CPU_RESETN), .d_i(phase_b), .q_o(b_sync));

  assign s = {a_sync, b_sync};

  dec_state_e          state_q, state_d;
  logic [1:0]          fill_q, fill_d;
  phase_t              prev_s_q, prev_s_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                pulse_q, pulse_d;
  logic [PERIOD_W-1:0] period_q, period_d, period_new;
  logic                pv_q, pv_d;
  logic                stalled_q, stalled_d;
  logic                err_q, err_d;
  logic                decoding, legal, illegal, fwd, stall_hit;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q   <= DEC_PRIME;
      fill_q    <= '0;
      prev_s_q  <= PH0;
      cnt_q     <= '0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      pulse_q   <= 1'b0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      stalled_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      prev_s_q  <= prev_s_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      pulse_q   <= pulse_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      stalled_q <= stalled_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    chg        = s ^ prev_s_q;
    decoding   = (state_q != DEC_PRIME);
    legal      = decoding && ((chg == 2'b01) || (chg == 2'b10));
    illegal    = decoding && (chg == 2'b11);
    fwd        = (phase_next(prev_s_q) == s);
    stall_hit  = (cnt_q == CNT_W'(STALL_LIMIT - 1));
    cnt_inc    = cnt_q + 1'b1;
    period_new = (cnt_inc > {{(CNT_W-PERIOD_W){1'b0}}, {PERIOD_W{1'b1}}})
                 ? {PERIOD_W{1'b1}} : cnt_inc[PERIOD_W-1:0];

    state_d   = state_q;
    fill_d    = fill_q;
    prev_s_d  = s;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    pulse_d   = legal;
    period_d  = period_q;
    pv_d      = pv_q;
    stalled_d = stalled_q;
    err_d     = err_q;

    if (legal) begin
      pos_d = fwd ? (pos_q + 1'b1) : (pos_q - 1'b1);
      dir_d = fwd;
    end
    if (clear) pos_d = '0;

    if (illegal)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;

    case (state_q)
      // Hold until both sync stages carry real pin levels; prev_s follows s
      // so the first post-reset level is taken as the reference, not a step.
      DEC_PRIME: begin
        if (fill_q == 2'd2) state_d = DEC_IDLE;
        else                fill_d  = fill_q + 2'd1;
      end
      DEC_IDLE: begin
        if (legal) begin
          state_d   = DEC_ARMED;
          cnt_d     = '0;
          stalled_d = 1'b0;
        end
      end
      DEC_ARMED, DEC_TRACK: begin
        if (legal) begin
          cnt_d = '0;
          if (fwd == dir_q) begin
            state_d  = DEC_TRACK;
            period_d = period_new;
            pv_d     = 1'b1;
          end else begin
            // reversal: the new direction needs a fresh reference step
            state_d = DEC_ARMED;
            pv_d    = 1'b0;
          end
        end else if (stall_hit) begin
          state_d   = DEC_IDLE;
          stalled_d = 1'b1;
          pv_d      = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = DEC_PRIME;
    endcase
  end

  assign position     = pos_q;
  assign dir          = dir_q;
  assign step_pulse   = pulse_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign stalled      = stalled_q;
  assign err          = err_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder. Narrow POS_W/PERIOD_W and a short stall
// limit keep wrap, saturation and stall reachable in a short run.
module tb_stepper_phase_decoder;

  localparam int PW  = 8;
  localparam int QW  = 8;
  localparam int LIM = 300;

  logic clk = 1'b0, rst_n = 1'b0, pa = 1'b1, pb = 1'b1, clr = 1'b0, eclr = 1'b0;
  logic signed [QW-1:0] position;
  logic [PW-1:0] period;
  logic dir, step_pulse, pv, stalled, err;

  stepper_phase_decoder #(.PERIOD_W(PW), .POS_W(QW), .STALL_LIMIT(LIM)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .phase_a(pa), .phase_b(pb),
    .clear(clr), .err_clr(eclr), .position(position), .dir(dir),
    .step_pulse(step_pulse), .period(period), .period_valid(pv),
    .stalled(stalled), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0;
  int t_e;
  logic [1:0] pins = 2'b11;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic check_all(input string nm, input int p, input bit d, input bit pl,
                           input bit e, input bit v, input int per, input bit st);
    chk({nm, ".pos"},    32'($unsigned(position)), 32'(p & 255));
    chk({nm, ".dir"},    32'(dir),        32'(d));
    chk({nm, ".pulse"},  32'(step_pulse), 32'(pl));
    chk({nm, ".err"},    32'(err),        32'(e));
    chk({nm, ".pvalid"}, 32'(pv),         32'(v));
    chk({nm, ".period"}, 32'(period),     32'(per));
    chk({nm, ".stall"},  32'(stalled),    32'(st));
  endtask

  // Phase codes by position in the forward cycle.
  function automatic int idx_of(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction
  function automatic logic [1:0] code_of(input int i);
    case ((i + 4) % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Changes the pins at a negedge (cycle T); strobes clear/err_clr onto the
  // edge where the change is decoded and returns at the sampling point T+3.
  task automatic apply(input logic [1:0] p, input bit c, input bit ec);
    pins = p;
    {pa, pb} = p;
    idle(2);
    chk("pulse_early", 32'(step_pulse), 32'd0);
    clr = c;
    eclr = ec;
    idle(1);
    t_e = cyc;
    clr = 1'b0;
    eclr = 1'b0;
  endtask

  typedef struct {
    logic [1:0] pins;
    bit c, ec;
    int pos;
    bit d, pl, e, v;
    int per;
  } vec_t;
  vec_t tbl[12];

  // reference model state
  int m_pos, m_per, last_e;
  bit m_dir, m_err, m_pv, m_st, have_ref, last_d;

  initial begin
    tbl[0]  = '{2'b10, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{2'b00, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 20};
    tbl[2]  = '{2'b01, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 20};
    tbl[3]  = '{2'b11, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b1, 20};
    tbl[4]  = '{2'b01, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 20};
    tbl[5]  = '{2'b00, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b1, 20};
    tbl[6]  = '{2'b11, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 20};
    tbl[7]  = '{2'b11, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 20};
    tbl[8]  = '{2'b00, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 20};
    tbl[9]  = '{2'b10, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 80};
    tbl[10] = '{2'b00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 80};
    tbl[11] = '{2'b01, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 20};

    // reset held with pins at 11, then released
    idle(3);
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("post_rst_pulse", 32'(step_pulse), 32'd0);
    end
    chk("post_rst_pos", 32'($unsigned(position)), 32'd0);

    // directed vectors, steps 20 cycles apart
    foreach (tbl[i]) begin
      apply(tbl[i].pins, tbl[i].c, tbl[i].ec);
      check_all($sformatf("tbl%0d", i), tbl[i].pos, tbl[i].d, tbl[i].pl,
                tbl[i].e, tbl[i].v, tbl[i].per, 1'b0);
      idle(17);
    end

    // stall: declared exactly STALL_LIMIT cycles after the last step
    while (cyc < t_e + LIM - 1) idle(1);
    chk("stall_early", 32'(stalled), 32'd0);
    idle(1);
    chk("stall_set", 32'(stalled), 32'd1);
    chk("stall_pv", 32'(pv), 32'd0);
    chk("stall_period_held", 32'(period), 32'd20);
    apply(2'b11, 1'b0, 1'b0);
    check_all("after_stall", 2, 1'b1, 1'b1, 1'b0, 1'b0, 20, 1'b0);
    idle(277);
    apply(2'b10, 1'b0, 1'b0);   // 280-cycle spacing saturates to 255
    check_all("sat", 3, 1'b1, 1'b1, 1'b0, 1'b1, 255, 1'b0);
    idle(297);
    apply(2'b00, 1'b0, 1'b0);   // step lands exactly at the stall limit
    check_all("limit_edge", 4, 1'b1, 1'b1, 1'b0, 1'b1, 255, 1'b0);
    idle(1);

    // position wrap at POS_W
    for (int i = 0; i < 123; i++) begin
      apply(code_of(idx_of(pins) + 1), 1'b0, 1'b0);
      idle(1);
    end
    chk("wrap_max", 32'($unsigned(position)), 32'h7f);
    apply(code_of(idx_of(pins) + 1), 1'b0, 1'b0);
    chk("wrap_min", 32'($unsigned(position)), 32'h80);
    chk("wrap_pulse", 32'(step_pulse), 32'd1);
    idle(1);
    apply(code_of(idx_of(pins) + 3), 1'b0, 1'b0);
    chk("wrap_back", 32'($unsigned(position)), 32'h7f);
    chk("wrap_back_dir", 32'(dir), 32'd0);
    idle(1);

    // reset with a step in flight through the synchronizers
    pins = code_of(idx_of(pins) + 1);
    {pa, pb} = pins;
    idle(1);
    rst_n = 1'b0;
    idle(1);
    check_all("midrst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("midrst_pulse", 32'(step_pulse), 32'd0);
    end
    chk("midrst_pos", 32'($unsigned(position)), 32'd0);

    // randomized steps against the reference model
    m_pos = 0; m_per = 0; last_e = 0;
    m_dir = 0; m_err = 0; m_pv = 0; m_st = 0; have_ref = 0; last_d = 0;
    for (int n = 0; n < 150; n++) begin
      logic [1:0] np;
      bit c, ec, lg, fw;
      int gap, k;
      np  = 2'($urandom_range(0, 3));
      c   = ($urandom_range(0, 7) == 0);
      ec  = ($urandom_range(0, 5) == 0);
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(LIM - 5, LIM + 20))
                                        : int'($urandom_range(4, 40));
      k   = (idx_of(np) - idx_of(pins) + 4) % 4;
      lg  = (k == 1) || (k == 3);
      fw  = (k == 1);
      apply(np, c, ec);
      if (have_ref && (lg ? (t_e > last_e + LIM) : (t_e >= last_e + LIM))) begin
        m_st = 1; m_pv = 0; have_ref = 0;
      end
      if (lg) begin
        if (have_ref) begin
          if (fw == last_d) begin
            m_per = (t_e - last_e > 255) ? 255 : t_e - last_e;
            m_pv  = 1;
          end else m_pv = 0;
        end
        m_st = 0; have_ref = 1; last_e = t_e; last_d = fw; m_dir = fw;
        m_pos = (m_pos + (fw ? 1 : 255)) % 256;
      end
      if (c) m_pos = 0;
      if (k == 2) m_err = 1;
      else if (ec) m_err = 0;
      check_all($sformatf("rnd%0d", n), m_pos, m_dir, lg, m_err, m_pv, m_per, m_st);
      idle(gap - 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
